// File: rtl/audio_decimator.sv
// Decimates an 8-bit unsigned sound stream by boxcar averaging, removes the DC
// level with a leaky integrator, and emits gain-scaled, saturated signed PCM.
module audio_decimator #(
    parameter int DECIM_LOG2 = 5,
    parameter int DC_SHIFT   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ce,
    input  logic [7:0]         SOUT,
    input  logic [1:0]         vol,
    input  logic               mute,
    output logic signed [15:0] pcm,
    output logic               pcm_valid
);
    // Flow control: no backpressure. SOUT is taken on every cycle with ce=1;
    // pcm_valid is a one-cycle strobe and pcm holds its value until the next one.

    localparam int AW = 8 + DECIM_LOG2;
    localparam int CW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam int DW = 16 + DC_SHIFT;
    localparam int XS = 8 - DECIM_LOG2;

    logic [AW-1:0]        acc;
    logic [CW-1:0]        cnt;
    logic [AW-1:0]        sum;
    logic                 win_close;

    logic [15:0]          x_u;
    logic                 s1_valid;

    logic [DW-1:0]        dc_acc;
    logic                 primed;
    logic [15:0]          dc;
    logic signed [16:0]   y_diff;
    logic signed [16:0]   y;
    logic signed [19:0]   g;
    logic signed [15:0]   pcm_next;
    logic [DW-1:0]        dc_acc_next;

    assign sum       = acc + AW'(SOUT);
    assign win_close = (DECIM_LOG2 == 0) || (cnt == CW'((1 << DECIM_LOG2) - 1));

    // Stage 0: window accumulation; the closing sample goes straight into sum.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (ce) begin
            if (win_close) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Stage 1: normalise the window sum to a 16-bit full-scale value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x_u      <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= ce && win_close;
            if (ce && win_close)
                x_u <= 16'(sum) << XS;
        end
    end

    // Stage 2: DC removal, gain, saturation, mute.
    assign dc     = dc_acc[DC_SHIFT +: 16];
    assign y_diff = $signed({1'b0, x_u}) - $signed({1'b0, dc});
    assign y      = primed ? y_diff : '0;
    assign g      = 20'(y) <<< vol;

    // The first sample after reset seeds the tracker so the output starts at zero.
    assign dc_acc_next = primed ? (dc_acc + DW'(y_diff)) : (DW'(x_u) << DC_SHIFT);

    always_comb begin
        pcm_next = '0;
        if (mute)
            pcm_next = '0;
        else if (g > 20'sd32767)
            pcm_next = 16'sh7fff;
        else if (g < -20'sd32768)
            pcm_next = 16'sh8000;
        else
            pcm_next = g[15:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dc_acc    <= '0;
            primed    <= 1'b0;
            pcm       <= '0;
            pcm_valid <= 1'b0;
        end else begin
            pcm_valid <= s1_valid;
            if (s1_valid) begin
                dc_acc <= dc_acc_next;
                primed <= 1'b1;
                pcm    <= pcm_next;
            end
        end
    end
endmodule

// File: tb/tb_audio_decimator.sv
// Bench for audio_decimator: directed and randomised windows checked against an
// arithmetic model of averaging, DC tracking, gain and saturation.
module tb_audio_decimator;
    localparam int D   = 5;
    localparam int DCS = 8;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               ce = 1'b0;
    logic [7:0]         sout = '0;
    logic [1:0]         vol = '0;
    logic               mute = 1'b0;
    logic signed [15:0] pcm;
    logic               pcm_valid;

    logic               ce0 = 1'b0;
    logic [7:0]         sout0 = '0;
    logic [1:0]         vol0 = '0;
    logic               mute0 = 1'b0;
    logic signed [15:0] pcm0;
    logic               pcm_valid0;

    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;
    int exp_pulses = 0;
    int cyc = 0;
    int last_pcm = 0;

    bit     m_primed = 1'b0;
    longint m_dcacc = 0;
    bit     m0_primed = 1'b0;
    longint m0_dcacc = 0;

    logic [15:0] exp_q[$];
    logic [15:0] exp0_q[$];
    logic [15:0] cap_pcm[$];
    int          cap_cyc[$];
    logic [15:0] cap0_pcm[$];
    int          cap0_cyc[$];

    audio_decimator #(.DECIM_LOG2(D), .DC_SHIFT(DCS)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .SOUT(sout), .vol(vol),
        .mute(mute), .pcm(pcm), .pcm_valid(pcm_valid)
    );

    audio_decimator #(.DECIM_LOG2(0), .DC_SHIFT(DCS)) dut0 (
        .clk(clk), .reset_n(reset_n), .ce(ce0), .SOUT(sout0), .vol(vol0),
        .mute(mute0), .pcm(pcm0), .pcm_valid(pcm_valid0)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    // Pulse monitor, sampled on the falling edge
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (pcm_valid) begin
            pulses <= pulses + 1;
            cap_pcm.push_back(pcm);
            cap_cyc.push_back(cyc);
        end
        if (pcm_valid0) begin
            cap0_pcm.push_back(pcm0);
            cap0_cyc.push_back(cyc);
        end
    end

    // Reference model: average, DC tracker, gain, clip, mute in plain arithmetic
    function automatic int emit(input int wsum, input int d, input int v, input bit m,
                                inout bit primed, inout longint dcacc);
        longint x  = longint'(wsum) * (64'sd1 << (8 - d));
        longint dc = dcacc / (64'sd1 << DCS);
        longint modv = 64'sd1 << (16 + DCS);
        longint yv;
        longint gv;
        if (!primed) begin
            dcacc  = x * (64'sd1 << DCS);
            yv     = 0;
            primed = 1'b1;
        end else begin
            yv    = x - dc;
            dcacc = (dcacc + yv) % modv;
            if (dcacc < 0) dcacc += modv;
        end
        gv = yv * (64'sd1 << v);
        if (gv > 32767) gv = 32767;
        if (gv < -32768) gv = -32768;
        if (m) gv = 0;
        return int'(gv);
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input bit ce_during);
        reset_n = 1'b0;
        ce      = ce_during;
        sout    = 8'($urandom);
        ce0     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pcm", pcm, 0);
        chk("rst_valid", 32'(pcm_valid), 0);
        reset_n   = 1'b1;
        ce        = 1'b0;
        m_primed  = 1'b0;
        m_dcacc   = 0;
        m0_primed = 1'b0;
        m0_dcacc  = 0;
        last_pcm  = 0;
    endtask

    // Drive n samples with random idle gaps before each; fixed<0 picks values near base
    task automatic drive_samples(input int n, input int fixed, input int base,
                                 input int min_gap, input int max_gap, input bit rand_ctl,
                                 output int wsum);
        int val;
        wsum = 0;
        for (int i = 0; i < n; i++) begin
            ce   = 1'b0;
            sout = 8'($urandom);
            repeat ($urandom_range(max_gap, min_gap)) @(negedge clk);
            if (rand_ctl && i == n / 2) begin
                vol  = 2'($urandom);
                mute = ($urandom_range(0, 3) == 0);
            end
            if (fixed >= 0) val = fixed;
            else begin
                val = base + int'($urandom_range(0, 40)) - 20;
                if (val < 0) val = 0;
                if (val > 255) val = 255;
            end
            ce   = 1'b1;
            sout = 8'(val);
            wsum += val;
            @(negedge clk);
        end
        ce   = 1'b0;
        sout = 8'($urandom);
    endtask

    task automatic finish_window(input int wsum, input string tag);
        int exp = emit(wsum, D, int'(vol), mute, m_primed, m_dcacc);
        chk({tag, "_t1_valid"}, 32'(pcm_valid), 0);
        chk({tag, "_t1_hold"}, pcm, last_pcm);
        @(negedge clk);
        chk({tag, "_t2_valid"}, 32'(pcm_valid), 1);
        chk({tag, "_t2_pcm"}, pcm, exp);
        last_pcm = exp;
        exp_pulses++;
        @(negedge clk);
        chk({tag, "_t3_valid"}, 32'(pcm_valid), 0);
        chk({tag, "_t3_hold"}, pcm, last_pcm);
    endtask

    initial begin
        int s;
        int p0;

        // Reset, prime with 100, then the 120 step twice
        do_reset(1'b0);
        drive_samples(32, 100, 0, 0, 0, 1'b0, s);
        finish_window(s, "prime100");
        chk("prime100_model", last_pcm, 0);
        drive_samples(32, 120, 0, 0, 0, 1'b0, s);
        finish_window(s, "step1");
        chk("step1_model", last_pcm, 5120);
        drive_samples(32, 120, 0, 0, 0, 1'b0, s);
        finish_window(s, "step2");
        chk("step2_model", last_pcm, 5100);

        // Positive and negative saturation
        do_reset(1'b0);
        drive_samples(32, 100, 0, 0, 1, 1'b0, s);
        finish_window(s, "sat_prime");
        vol = 2'd3;
        drive_samples(32, 120, 0, 0, 1, 1'b0, s);
        finish_window(s, "sat_pos");
        chk("sat_pos_model", last_pcm, 32767);
        do_reset(1'b0);
        vol = 2'd0;
        drive_samples(32, 100, 0, 0, 0, 1'b0, s);
        finish_window(s, "sat_prime2");
        vol = 2'd3;
        drive_samples(32, 0, 0, 0, 0, 1'b0, s);
        finish_window(s, "sat_neg");
        chk("sat_neg_model", last_pcm, -32768);

        // Mute keeps DC tracking running
        do_reset(1'b0);
        vol = 2'd0;
        drive_samples(32, 100, 0, 0, 0, 1'b0, s);
        finish_window(s, "mute_prime");
        mute = 1'b1;
        drive_samples(32, 120, 0, 0, 0, 1'b0, s);
        finish_window(s, "mute_on");
        mute = 1'b0;
        drive_samples(32, 120, 0, 0, 0, 1'b0, s);
        finish_window(s, "mute_off");
        chk("mute_off_model", last_pcm, 5100);

        // Partial window discarded by reset held with ce=1
        drive_samples(17, 77, 0, 0, 0, 1'b0, s);
        p0 = pulses;
        do_reset(1'b1);
        repeat (3) @(negedge clk);
        chk("partial_nopulse", pulses, p0);
        drive_samples(32, 50, 0, 0, 0, 1'b0, s);
        finish_window(s, "rst_prime50");
        drive_samples(32, 60, 0, 0, 0, 1'b0, s);
        finish_window(s, "after50");
        chk("after50_model", last_pcm, 2560);

        // In-flight sample dropped by reset right after window close
        drive_samples(32, 200, 0, 0, 0, 1'b0, s);
        p0 = pulses;
        do_reset(1'b0);
        repeat (3) @(negedge clk);
        chk("flight_nopulse", pulses, p0);

        // ce every third cycle: 96-cycle pulse spacing
        drive_samples(32, 100, 0, 0, 0, 1'b0, s);
        finish_window(s, "sp_prime");
        repeat (3) @(negedge clk);
        cap_pcm.delete();
        cap_cyc.delete();
        exp_q.delete();
        for (int w = 0; w < 3; w++) begin
            drive_samples(32, -1, int'($urandom_range(60, 200)), 2, 2, 1'b0, s);
            exp_q.push_back(16'(emit(s, D, int'(vol), mute, m_primed, m_dcacc)));
        end
        repeat (4) @(negedge clk);
        exp_pulses += 3;
        chk("sp_count", cap_pcm.size(), 3);
        for (int i = 0; i < 3 && i < cap_pcm.size(); i++) begin
            chk("sp_pcm", $signed(cap_pcm[i]), $signed(exp_q[i]));
            if (i > 0) chk("sp_spacing", cap_cyc[i] - cap_cyc[i-1], 96);
        end
        last_pcm = int'($signed(exp_q[2]));

        // Randomised windows with gaps and mid-window vol/mute changes
        for (int w = 0; w < 16; w++) begin
            drive_samples(32, -1, int'($urandom_range(0, 255)), 0, 3, 1'b1, s);
            finish_window(s, "rand");
        end

        // DECIM_LOG2=0 with ce held high: one output per cycle
        do_reset(1'b0);
        cap0_pcm.delete();
        cap0_cyc.delete();
        exp0_q.delete();
        vol0 = 2'($urandom);
        for (int i = 0; i < 20; i++) begin
            ce0   = 1'b1;
            sout0 = 8'($urandom);
            exp0_q.push_back(16'(emit(int'(sout0), 0, int'(vol0), 1'b0, m0_primed, m0_dcacc)));
            @(negedge clk);
        end
        ce0 = 1'b0;
        repeat (4) @(negedge clk);
        chk("d0_count", cap0_pcm.size(), 20);
        for (int i = 0; i < 20 && i < cap0_pcm.size(); i++) begin
            chk("d0_pcm", $signed(cap0_pcm[i]), $signed(exp0_q[i]));
            if (i > 0) chk("d0_spacing", cap0_cyc[i] - cap0_cyc[i-1], 1);
        end

        chk("pulse_total", pulses, exp_pulses);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
